// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM states, default
// frame geometry and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int TICK_W         = $clog2(DEF_OVERSAMPLE);

  // Width needed to count 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Counts oversample ticks within one bit period and flags the tick that ends the bit.
// clr restarts the bit period; it takes priority over counting.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic bit_done
);

  localparam int W = cnt_w(OVERSAMPLE);

  logic [W-1:0] tick_cnt;

  assign bit_done = tick && (tick_cnt == W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 tick_cnt <= '0;
    else if (clr || bit_done) tick_cnt <= '0;
    else if (tick)            tick_cnt <= tick_cnt + 1'b1;
  end

endmodule

// File: rtl/transmitter.sv
// UART transmitter: start, DATA_W bits LSB-first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module transmitter
  import uart_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_enable,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  output logic              txd,
  output logic              tbr,
  output logic              tx_busy
);

  localparam int BIT_W = cnt_w(DATA_W);

  state_t            state, state_nx;
  logic [DATA_W-1:0] hold, shift, shift_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              bit_done, xfer, txd_nx, tick_en;
`ifdef UART_TX_PARITY_EN
  logic              par, par_nx;
`endif

  // Ticks only advance the bit timer while a frame is on the line.
  assign tick_en = t_enable && (state != IDLE);
  assign tx_busy = (state != IDLE);

  uart_baud_counter #(.OVERSAMPLE(OVERSAMPLE)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (xfer),
    .tick     (tick_en),
    .bit_done (bit_done)
  );

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    xfer       = 1'b0;
    txd_nx     = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_nx     = par;
`endif
    case (state)
      IDLE:  xfer = !tbr;
      START: if (bit_done) state_nx = DATA;
      DATA: begin
        if (bit_done) begin
          shift_nx = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_W - 1))
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          else
            bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      PARITY: if (bit_done) state_nx = STOP;
      STOP: begin
        if (bit_done) begin
          if (!tbr) xfer = 1'b1;
          else      state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Holding register moves into the shifter; this also chains frames with no idle gap.
    if (xfer) begin
      state_nx   = START;
      shift_nx   = hold;
      bit_cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
      par_nx     = ^hold;
`endif
    end

    // txd is registered from the next state so the line never glitches.
    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_nx = par_nx;
`endif
      default: txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bit_cnt <= bit_cnt_nx;
      txd     <= txd_nx;
`ifdef UART_TX_PARITY_EN
      par     <= par_nx;
`endif
    end
  end

  // Loads only land in an empty buffer; a full buffer is never overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      tbr  <= 1'b1;
    end else if (tx_load && tbr) begin
      hold <= tx_data;
      tbr  <= 1'b0;
    end else if (xfer) begin
      tbr  <= 1'b1;
    end
  end

endmodule
